// File: rtl/tile_reveal_ctrl.sv
// tile_reveal_ctrl -- score-gated tile reveal overlay for a scanned image.
//
// Purpose: turns timing-generator coordinates into an image RAM address,
// delays the coordinates to line up with the RAM read data, and blanks or
// passes each pixel depending on how many tiles of a COLS x ROWS grid the
// player has earned. Newly earned tiles are revealed with a top-down wipe
// that advances WIPE_STEP lines per frame. A lower score hides tiles at once.
//
// Ports:
//   clk        pixel clock (only clock)
//   reset      synchronous, active-high
//   x, y       pixel coordinates from the timing generator
//   active     active-pixel flag
//   screenEnd  one-cycle frame-boundary pulse (score is sampled here only)
//   ingame     1 = score-gated reveal, 0 = attract mode (all tiles shown)
//   score      unsigned tile count, saturated to TILES
//   img_addr   image RAM address, x + H_RES*y (combinational)
//   pix_data   RAM read data, valid RAM_LAT cycles after img_addr
//   color_out  registered RGB444 output, RAM_LAT+1 cycles after x/y
//   active_out active delayed to line up with color_out
//
// Build option: define TILE_GRID_LINES_EN to draw white grid lines on the
// first column/row of every tile (overrides the reveal mask while active).
module tile_reveal_ctrl #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int COLS      = 4,
  parameter int ROWS      = 3,
  parameter int TILE_W    = 160,
  parameter int TILE_H    = 160,
  parameter int RAM_LAT   = 2,
  parameter int WIPE_STEP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        active,
  input  logic        screenEnd,
  input  logic        ingame,
  input  logic [31:0] score,
  output logic [19:0] img_addr,
  input  logic [11:0] pix_data,
  output logic [11:0] color_out,
  output logic        active_out
);

  localparam int TILES  = COLS * ROWS;
  localparam int CNT_W  = $clog2(TILES + 1);
  localparam int WL_W   = $clog2(TILE_H + WIPE_STEP);
  localparam int STAGES = RAM_LAT - 1;   // vld_pipe[STAGES] lines up with pix_data
  localparam int GRID_W = COLS * TILE_W;
  localparam int GRID_H = ROWS * TILE_H;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } coord_t;

  typedef enum logic {IDLE, WIPE} state_t;

  coord_t [STAGES:0] crd_pipe;
  logic   [STAGES:0] vld_pipe;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  shown_lo, shown_lo_nx;
  logic [CNT_W-1:0]  shown_hi, shown_hi_nx;
  logic [WL_W-1:0]   wipe_line, wipe_line_nx;
  logic [WL_W:0]     wl_sum;
  logic [CNT_W-1:0]  score_sat;

  logic [9:0]        xd;
  logic [8:0]        yd;
  logic [31:0]       tile_idx, tile_row;
  logic              in_grid, shown;
  logic [11:0]       color_nx;

  assign img_addr = 20'(x) + 20'(H_RES) * 20'(y);

  // ---------------- reveal FSM ----------------
  assign score_sat = (score > 32'(TILES)) ? CNT_W'(TILES) : CNT_W'(score);
  assign wl_sum    = {1'b0, wipe_line} + (WL_W+1)'(WIPE_STEP);

  always_comb begin
    state_nx     = state;
    shown_lo_nx  = shown_lo;
    shown_hi_nx  = shown_hi;
    wipe_line_nx = wipe_line;
    if (screenEnd) begin
      case (state)
        IDLE: begin
          if (score_sat > shown_lo) begin
            shown_hi_nx  = score_sat;
            wipe_line_nx = '0;
            state_nx     = WIPE;
          end else if (score_sat < shown_lo) begin
            // losing tiles is instant: no reverse animation
            shown_lo_nx = score_sat;
            shown_hi_nx = score_sat;
          end
        end
        WIPE: begin
          // score is deliberately not looked at here; a change waits for IDLE
          if (wl_sum >= (WL_W+1)'(TILE_H)) begin
            shown_lo_nx  = shown_hi;
            wipe_line_nx = '0;
            state_nx     = IDLE;
          end else begin
            wipe_line_nx = wl_sum[WL_W-1:0];
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------- pixel mask (at the pix_data stage) ----------------
  assign xd       = crd_pipe[STAGES].x;
  assign yd       = crd_pipe[STAGES].y;
  assign in_grid  = (32'(xd) < 32'(GRID_W)) && (32'(yd) < 32'(GRID_H));
  assign tile_idx = (32'(yd) / 32'(TILE_H)) * 32'(COLS) + 32'(xd) / 32'(TILE_W);
  assign tile_row = 32'(yd) % 32'(TILE_H);
  // tiles in [shown_lo, shown_hi) are mid-wipe: only rows above wipe_line show
  assign shown    = !ingame || (tile_idx < 32'(shown_lo)) ||
                    ((tile_idx < 32'(shown_hi)) && (tile_row < 32'(wipe_line)));

  always_comb begin
    color_nx = 12'h000;
    if (vld_pipe[STAGES] && in_grid && shown) color_nx = pix_data;
`ifdef TILE_GRID_LINES_EN
    if (vld_pipe[STAGES] && in_grid &&
        ((32'(xd) % 32'(TILE_W) == 0) || (32'(yd) % 32'(TILE_H) == 0)))
      color_nx = 12'hFFF;
`endif
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      crd_pipe   <= '0;
      vld_pipe   <= '0;
      state      <= IDLE;
      shown_lo   <= '0;
      shown_hi   <= '0;
      wipe_line  <= '0;
      color_out  <= '0;
      active_out <= 1'b0;
    end else begin
      crd_pipe[0] <= '{x: x, y: y};
      vld_pipe[0] <= active;
      for (int i = 1; i <= STAGES; i++) begin
        crd_pipe[i] <= crd_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
      state      <= state_nx;
      shown_lo   <= shown_lo_nx;
      shown_hi   <= shown_hi_nx;
      wipe_line  <= wipe_line_nx;
      color_out  <= color_nx;
      active_out <= vld_pipe[STAGES];
    end
  end

endmodule

// File: tb/tb_tile_reveal_ctrl.sv
// Scoreboard bench for tile_reveal_ctrl on a shrunk raster (16x16 active,
// 4x3 tiles of 3x5, two lines of wipe per frame). The driver scans frames,
// pushes the expected colour of every active pixel from a frame-level
// reference model, and a negedge monitor pops and compares whenever the DUT
// raises active_out.
module tb_tile_reveal_ctrl;
  localparam int H_RES = 16, V_RES = 16, COLS = 4, ROWS = 3;
  localparam int TW = 3, TH = 5, RAM_LAT = 2, WSTEP = 2;
  localparam int H_TOT = H_RES + 4, V_TOT = V_RES + 2;
  localparam int TILES = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        active = 1'b0, screenEnd = 1'b0, ingame = 1'b1;
  logic [31:0] score = '0;
  logic [19:0] img_addr;
  logic [11:0] pix_data;
  logic [11:0] color_out;
  logic        active_out;

  tile_reveal_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .COLS(COLS), .ROWS(ROWS),
    .TILE_W(TW), .TILE_H(TH), .RAM_LAT(RAM_LAT), .WIPE_STEP(WSTEP)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .screenEnd(screenEnd), .ingame(ingame), .score(score),
    .img_addr(img_addr), .pix_data(pix_data), .color_out(color_out),
    .active_out(active_out));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [11:0] exp_q[$];
  bit [2:0] act_hist = '0;

  // image RAM: content is a hash of the address, never zero
  function automatic logic [11:0] ram_f(input int a);
    return 12'((a * 173) ^ 32'h5A5) | 12'h001;
  endfunction

  logic [11:0] ram_q0 = '0, ram_q1 = '0;
  always @(posedge clk) begin
    ram_q0 <= ram_f(int'(img_addr));
    ram_q1 <= ram_q0;
  end
  assign pix_data = ram_q1;

  // ---------------- reference model ----------------
  int m_lo, m_hi, m_wipe;   // fully shown tiles, target tiles, wipe rows shown
  bit m_wiping;

  task automatic model_reset();
    m_lo = 0; m_hi = 0; m_wipe = 0; m_wiping = 0;
  endtask

  task automatic model_frame_end(input int unsigned sc);
    int sat;
    sat = (sc > TILES) ? TILES : int'(sc);
    if (m_wiping) begin
      m_wipe += WSTEP;
      if (m_wipe >= TH) begin m_lo = m_hi; m_wipe = 0; m_wiping = 0; end
    end else if (sat > m_lo) begin
      m_hi = sat; m_wipe = 0; m_wiping = 1;
    end else if (sat < m_lo) begin
      m_lo = sat; m_hi = sat;
    end
  endtask

  function automatic logic [11:0] exp_color(input int xx, input int yy);
    int idx, row;
    bit vis;
    if (xx >= COLS * TW || yy >= ROWS * TH) return 12'h000;
`ifdef TILE_GRID_LINES_EN
    if (xx % TW == 0 || yy % TH == 0) return 12'hFFF;
`endif
    idx = (yy / TH) * COLS + xx / TW;
    row = yy % TH;
    vis = !ingame || idx < m_lo || (idx < m_hi && row < m_wipe);
    return vis ? ram_f(xx + H_RES * yy) : 12'h000;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) act_hist <= {act_hist[1:0], active};

  always @(negedge clk) begin
    if (!reset) begin
      check(img_addr == 20'(int'(x) + H_RES * int'(y)), "img_addr", 32'(img_addr),
            32'(int'(x) + H_RES * int'(y)));
      check(active_out == act_hist[2], "active_lag", 32'(active_out), 32'(act_hist[2]));
      if (active_out) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_pixel", 32'(color_out), 32'h0);
        else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check(color_out == e, "color", 32'(color_out), 32'(e));
        end
      end else begin
        check(color_out == 12'h000, "color_blank", 32'(color_out), 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_frame(input int unsigned sc, input bit junk);
    for (int yy = 0; yy < V_TOT; yy++)
      for (int xx = 0; xx < H_TOT; xx++) begin
        bit last;
        @(posedge clk); #1;
        last      = (xx == H_TOT - 1) && (yy == V_TOT - 1);
        x         = 10'(xx);
        y         = 9'(yy);
        active    = (xx < H_RES) && (yy < V_RES);
        screenEnd = last;
        if (last) score = sc;
        else if (junk) score = $urandom_range(0, 40);
        if (active) exp_q.push_back(exp_color(xx, yy));
        if (last) model_frame_end(sc);
      end
  endtask

  task automatic run_frames(input int n, input int unsigned sc, input bit junk);
    for (int i = 0; i < n; i++) run_frame(sc, junk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      active = 1'b0; screenEnd = 1'b0; x = '0; y = '0;
    end
  endtask

  task automatic do_reset();
    idle_cycles(6);
    check(exp_q.size() == 0, "drain_before_reset", 32'(exp_q.size()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(color_out == 12'h000, "reset_color", 32'(color_out), 32'h0);
    check(active_out == 1'b0, "reset_active", 32'(active_out), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(color_out == 12'h000, "reset_color", 32'(color_out), 32'h0);
    check(active_out == 1'b0, "reset_active", 32'(active_out), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    ingame = 1'b1;
    run_frames(2, 0, 1'b0);        // black screen
    run_frames(5, 3, 1'b1);        // wipe tiles 0..2, then idle
    do_reset();
    run_frames(2, 3, 1'b0);        // start wipe to 3
    run_frames(6, 5, 1'b1);        // 5 ignored mid-wipe, second wipe afterwards
    run_frames(5, 100, 1'b0);      // saturate to all tiles
    run_frames(2, 2, 1'b1);        // instant drop to 2 tiles
    do_reset();
    run_frames(2, 7, 1'b0);        // mid-wipe
    do_reset();                    // abort the animation
    run_frames(6, 7, 1'b0);        // restarts from tile 0
    ingame = 1'b0;
    run_frames(2, 0, 1'b0);        // attract mode
    for (int f = 0; f < 20; f++) begin
      ingame = ($urandom_range(0, 3) != 0);
      run_frame($urandom_range(0, 16), 1'(f % 2));
    end

    idle_cycles(6);
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_reveal_ctrl.md
TILE_REVEAL_CTRL -- requirements
Module: tile_reveal_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-003 SHALL have parameters COLS/ROWS, default 4/3, tile grid dimensions; TILES = COLS*ROWS.
REQ-004 SHALL have parameters TILE_W/TILE_H, default 160/160, tile size in pixels; COLS*TILE_W <= H_RES, ROWS*TILE_H <= V_RES.
REQ-005 SHALL have parameter RAM_LAT, default 2, cycles from img_addr to valid pix_data.
REQ-006 SHALL have parameter WIPE_STEP, default 16, wipe advance in lines per frame.
REQ-007 SHALL have port clk, input, 1, pixel clock; the block's only clock.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports x (10 bits) and y (9 bits), inputs, pixel coordinates from the timing generator.
REQ-010 SHALL have ports active and screenEnd, inputs, 1 each: active-pixel flag and one-cycle frame-boundary pulse.
REQ-011 SHALL have port ingame, input, 1: 1 = score-gated reveal, 0 = attract mode with all tiles shown.
REQ-012 SHALL have port score, input, 32, unsigned count of tiles to reveal.
REQ-013 SHALL have port img_addr, output, 20, image RAM address.
REQ-014 SHALL have port pix_data, input, 12, palette colour returned by RAM.
REQ-015 SHALL have port color_out, output, 12, registered RGB444.
REQ-016 SHALL have port active_out, output, 1, active delayed to align with color_out.

Function
REQ-017 SHALL drive img_addr = x + H_RES*y combinationally.
REQ-018 SHALL delay x, y and active through a RAM_LAT-deep register pipeline aligned with pix_data.
REQ-019 SHALL register color_out and active_out one cycle after pix_data; total latency RAM_LAT+1 cycles from x/y.
REQ-020 SHALL compute tile index = (y/TILE_H)*COLS + x/TILE_W and in-tile row = y mod TILE_H from the delayed coordinates.
REQ-021 SHALL sample score only in cycles where screenEnd=1, saturating at TILES (score_sat = min(score, TILES)).
REQ-022 SHALL hold registers shown_lo and shown_hi (clog2(TILES+1) bits each) and wipe_line (clog2(TILE_H+WIPE_STEP) bits).
REQ-023 SHALL implement FSM IDLE/WIPE: IDLE and screenEnd and score_sat > shown_lo -> shown_hi = score_sat, wipe_line = 0, go to WIPE.
REQ-024 SHALL in IDLE, on screenEnd with score_sat < shown_lo, set shown_lo = shown_hi = score_sat immediately, without animation.
REQ-025 SHALL in WIPE, on each screenEnd, add WIPE_STEP to wipe_line; if the sum >= TILE_H, set shown_lo = shown_hi, wipe_line = 0, go to IDLE.
REQ-026 SHALL ignore score changes while in WIPE; a pending change is taken on the first screenEnd in IDLE.
REQ-027 SHALL show a pixel if index < shown_lo, or if shown_lo <= index < shown_hi and in-tile row < wipe_line.
REQ-028 SHALL show every in-grid pixel when ingame=0; the FSM keeps running.
REQ-029 SHALL drive color_out = pix_data for shown pixels, else 12'h000; 12'h000 also when the delayed active=0 or the pixel lies outside the COLS x ROWS grid.

Reset
REQ-030 SHALL on reset set the FSM to IDLE, shown_lo = shown_hi = wipe_line = 0, and clear color_out, active_out and all pipeline stages to 0.
REQ-031 SHALL on reset mid-WIPE abort the animation; the next screenEnd in IDLE restarts the reveal from tile 0.

Configuration
REQ-032 SHALL, with macro TILE_GRID_LINES_EN defined, draw color_out = 12'hFFF on in-grid pixels with x mod TILE_W = 0 or y mod TILE_H = 0, overriding REQ-027/REQ-029 while active.
REQ-033 SHALL, without TILE_GRID_LINES_EN, contain no grid-line logic; behaviour is exactly REQ-017..REQ-031.

Verification
REQ-034 Reset, ingame=1, score=0 for a full frame -> color_out = 0 on all pixels; active_out lags active by 3 cycles.
REQ-035 score=3 at screenEnd -> WIPE; after frame 1, tiles 0..2 show rows 0..15; after 10 frames, IDLE with shown_lo = 3.
REQ-036 score=100 -> saturates to 12; all tiles revealed after the wipe; pixel (639,479) = pix_data.
REQ-037 score 3->5 mid-WIPE -> first wipe completes for tiles 0..2; second wipe for tiles 3..4 starts at the next IDLE screenEnd.
REQ-038 From IDLE with shown_lo = 8, score=2 -> the next frame shows tiles 0..1 only, with no WIPE entry.
REQ-039 ingame=0, score=0 -> full image shown; with TILE_GRID_LINES_EN, pixel (160,37) = 12'hFFF.
